fpu_mul_arbiter: RTL and testbench

FPU_MUL_ARBITER -- requirements
Module: fpu_mul_arbiter

---
 rtl/fpu_mul_arbiter_if.sv | 36 +++
 rtl/fpu_mul_arbiter.sv | 167 ++++++++++++++++
 tb/tb_fpu_mul_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_mul_arbiter_if.sv
// Bundle of the two requester channels, the shared response channel and the multiplier port.
// Requests: reqN_ready pulses in the cycle reqN_valid/a/b are taken; responses pulse once with no backpressure.
interface fpu_mul_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_result;
    logic        rsp_err;
    logic        fpu_start;
    logic [31:0] fpu_n1;
    logic [31:0] fpu_n2;
    logic [31:0] fpu_result;
    logic        fpu_done;
    logic        fpu_busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        input  fpu_result, fpu_done, fpu_busy,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_err,
        output fpu_start, fpu_n1, fpu_n2
    );

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
        output fpu_result, fpu_done, fpu_busy,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_result, rsp_err,
        input  fpu_start, fpu_n1, fpu_n2
    );
endinterface

// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter sharing one multiplier between two requesters, one operation in flight.
// Defining FPU_ARB_TIMEOUT_EN adds an ISSUE-phase timeout that answers with a quiet NaN and rsp_err.
module fpu_mul_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fpu_mul_arbiter_if.slave        bus,
    output logic [1:0]              o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_last;
    logic        r_owner;
    logic        r_armed;
    logic [31:0] r_n1;
    logic [31:0] r_n2;
    logic [31:0] r_result;
    logic        w_any;
    logic        w_grant;
    logic        w_grant_id;
    logic        w_capture;

`ifdef FPU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] QNAN = 32'h7FC00000;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_timeout;
`endif

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        w_any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_id = ~r_last;
        end else begin
            w_grant_id = bus.req1_valid;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_capture    = 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
        w_timeout    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (r_armed && w_any) begin
                    w_grant      = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.fpu_done) begin
                    w_capture    = 1'b1;
                    w_next_state = RELEASE;
                end
`ifdef FPU_ARB_TIMEOUT_EN
                else if (r_cnt == CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = RELEASE;
                end
`endif
            end
            RELEASE: begin
                if (!bus.fpu_done) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // r_armed blocks grants after reset until the multiplier is seen idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_armed  <= 1'b0;
            r_n1     <= 32'd0;
            r_n2     <= 32'd0;
            r_result <= 32'd0;
        end else begin
            if (r_state == IDLE && !bus.fpu_done) begin
                r_armed <= 1'b1;
            end
            if (w_grant) begin
                r_last  <= w_grant_id;
                r_owner <= w_grant_id;
                r_n1    <= w_grant_id ? bus.req1_a : bus.req0_a;
                r_n2    <= w_grant_id ? bus.req1_b : bus.req0_b;
            end
            if (w_capture) begin
                r_result <= bus.fpu_result;
            end
`ifdef FPU_ARB_TIMEOUT_EN
            else if (w_timeout) begin
                r_result <= QNAN;
            end
`endif
        end
    end

`ifdef FPU_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_grant) begin
                r_cnt <= '0;
            end else if (r_state == ISSUE) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_grant || w_capture) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    logic w_unused;
    assign w_unused    = bus.fpu_busy;
    assign bus.rsp_err = (r_state == RESP) & r_err;
`else
    logic w_unused;
    assign w_unused    = bus.fpu_busy ^ (TIMEOUT_CYCLES > 0);
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req0_ready = w_grant & ~w_grant_id;
    assign bus.req1_ready = w_grant & w_grant_id;
    assign bus.rsp0_valid = (r_state == RESP) & ~r_owner;
    assign bus.rsp1_valid = (r_state == RESP) & r_owner;
    assign bus.rsp_result = r_result;
    assign bus.fpu_start  = (r_state == ISSUE);
    assign bus.fpu_n1     = r_n1;
    assign bus.fpu_n2     = r_n2;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Bench for fpu_mul_arbiter: vector table, reset corner cases, random traffic against a scoreboard.
// Build with FPU_ARB_TIMEOUT_EN defined to also exercise the timeout path.
module tb_fpu_mul_arbiter;
    localparam int TIMEOUT = 16;
    localparam int W = 98;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic        first;
        logic [31:0] r_first;
        logic [31:0] r_second;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         total = 0;
    int         bad = 0;
    int         stub_mode = 0;
    int         stub_lat = 0;
    int         lat = 0;
    int         start_cycles = 0;
    logic       last_grant = 1'b1;
    logic [W-1:0] exp_q[$];
    logic [33:0]  rsp_log[$];
    vec_t         vecs[5];

    logic         m_g;
    logic         m_e;
    logic [31:0]  m_a;
    logic [31:0]  m_b;
    logic [W-1:0] m_item;

    fpu_mul_arbiter_if bus ();

    fpu_mul_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Single-precision product of two normal numbers, truncated.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] prod;
        int          exp_sum;
        logic [22:0] frac;
        prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        exp_sum = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (prod[47]) begin
            exp_sum++;
            frac = prod[46:24];
        end else begin
            frac = prod[45:23];
        end
        return {a[31] ^ b[31], exp_sum[7:0], frac};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v[31]    = 1'($urandom_range(0, 1));
        v[30:23] = 8'($urandom_range(100, 154));
        v[22:0]  = 23'($urandom);
        return v;
    endfunction

    // Multiplier stub: done after a short latency, drops some cycles after start falls.
    initial begin
        bus.fpu_done   = 1'b0;
        bus.fpu_result = 32'd0;
        bus.fpu_busy   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stub_mode == 1) begin
                bus.fpu_done = 1'b0;
            end else if (stub_mode == 2) begin
                bus.fpu_done = 1'b1;
            end else if (bus.fpu_start) begin
                if (!bus.fpu_done) begin
                    if (lat == 0) begin
                        bus.fpu_done   = 1'b1;
                        bus.fpu_result = fp_mul(bus.fpu_n1, bus.fpu_n2);
                    end else begin
                        lat--;
                    end
                end
            end else begin
                if (bus.fpu_done) begin
                    bus.fpu_done = ($urandom_range(0, 2) == 0);
                end
                lat = stub_lat + int'($urandom_range(0, 2));
            end
            bus.fpu_busy = bus.fpu_start & ~bus.fpu_done;
        end
    end

    // Scoreboard: grants checked against round-robin rules, responses against exp_q.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last_grant   = 1'b1;
            start_cycles = 0;
        end else begin
            if (bus.fpu_start) begin
                start_cycles++;
                check("start_has_op", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("fpu_n1_stable", bus.fpu_n1, exp_q[0][95:64]);
                    check("fpu_n2_stable", bus.fpu_n2, exp_q[0][63:32]);
                end
            end
            if (bus.req0_ready || bus.req1_ready) begin
                check("one_ready", bus.req0_ready & bus.req1_ready, 0);
                m_g = bus.req1_ready;
                check("ready_has_valid", m_g ? bus.req1_valid : bus.req0_valid, 1);
                if (bus.req0_valid && bus.req1_valid) begin
                    check("rr_winner", m_g, !last_grant);
                end
                check("grant_in_flight", exp_q.size(), 0);
                last_grant   = m_g;
                m_a          = m_g ? bus.req1_a : bus.req0_a;
                m_b          = m_g ? bus.req1_b : bus.req0_b;
                m_e          = (stub_mode == 1);
                start_cycles = 0;
                exp_q.push_back({m_g, m_e, m_a, m_b, m_e ? 32'h7FC00000 : fp_mul(m_a, m_b)});
            end
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                check("one_rsp", bus.rsp0_valid & bus.rsp1_valid, 0);
                check("rsp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    m_item = exp_q.pop_front();
                    check("rsp_owner", bus.rsp1_valid, m_item[97]);
                    check("rsp_err", bus.rsp_err, m_item[96]);
                    check("rsp_result", bus.rsp_result, m_item[31:0]);
`ifdef FPU_ARB_TIMEOUT_EN
                    if (m_item[96]) begin
                        check("timeout_issue_cycles", start_cycles, TIMEOUT);
                    end
`endif
                end
                rsp_log.push_back({bus.rsp1_valid, bus.rsp_err, bus.rsp_result});
            end else begin
                check("err_without_rsp", bus.rsp_err, 0);
            end
        end
    end

    task automatic set_req(input int n, input logic v, input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            bus.req0_valid = v;
            bus.req0_a     = a;
            bus.req0_b     = b;
        end else begin
            bus.req1_valid = v;
            bus.req1_a     = a;
            bus.req1_b     = b;
        end
    endtask

    task automatic wait_ready(input int n);
        int   waited = 0;
        logic seen = 1'b0;
        while (!seen && waited < 200) begin
            @(negedge clk);
            seen = (n == 0) ? bus.req0_ready : bus.req1_ready;
            waited++;
        end
        check("ready_within_bound", seen, 1);
    endtask

    // Holds valid until accepted, then drops it and scrambles the operands.
    task automatic drive_req(input int n, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        set_req(n, 1'b1, a, b);
        wait_ready(n);
        @(posedge clk);
        #1;
        set_req(n, 1'b0, $urandom, $urandom);
    endtask

    task automatic wait_rsp(input int n);
        int waited = 0;
        while (rsp_log.size() < n && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        check("rsp_count", rsp_log.size(), n);
    endtask

    task automatic apply_vec(input vec_t v);
        int n;
        n = int'(v.v0) + int'(v.v1);
        rsp_log.delete();
        fork
            begin if (v.v0) drive_req(0, v.a0, v.b0); end
            begin if (v.v1) drive_req(1, v.a1, v.b1); end
        join
        wait_rsp(n);
        if (rsp_log.size() >= 1) begin
            check("vec_first_owner", rsp_log[0][33], v.first);
            check("vec_first_result", rsp_log[0][31:0], v.r_first);
        end
        if (n == 2 && rsp_log.size() >= 2) begin
            check("vec_second_owner", rsp_log[1][33], !v.first);
            check("vec_second_result", rsp_log[1][31:0], v.r_second);
        end
    endtask

    initial begin
        #300000;
        bad++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        rst_n = 1'b1;
        set_req(0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 32'd0, 32'd0);
        vecs[0] = '{1'b1, 1'b1, 32'h40000000, 32'h40400000, 32'hC0000000, 32'h3F800000, 1'b0, 32'h40C00000, 32'hC0000000};
        vecs[1] = '{1'b1, 1'b1, 32'h3F800000, 32'h3F800000, 32'h40800000, 32'h3F000000, 1'b0, 32'h3F800000, 32'h40000000};
        vecs[2] = '{1'b0, 1'b1, 32'd0, 32'd0, 32'hC0000000, 32'h3F800000, 1'b1, 32'hC0000000, 32'd0};
        vecs[3] = '{1'b1, 1'b0, 32'h40000000, 32'h40400000, 32'd0, 32'd0, 1'b0, 32'h40C00000, 32'd0};
        vecs[4] = '{1'b1, 1'b1, 32'hBF800000, 32'h40000000, 32'h40400000, 32'h40400000, 1'b1, 32'h41100000, 32'hC0000000};

        #2 rst_n = 1'b0;
        set_req(0, 1'b1, 32'h40000000, 32'h40400000);
        set_req(1, 1'b1, 32'hC0000000, 32'h3F800000);
        #2;
        check("reset_req0_ready", bus.req0_ready, 0);
        check("reset_req1_ready", bus.req1_ready, 0);
        check("reset_rsp0_valid", bus.rsp0_valid, 0);
        check("reset_rsp1_valid", bus.rsp1_valid, 0);
        check("reset_rsp_err", bus.rsp_err, 0);
        check("reset_fpu_start", bus.fpu_start, 0);
        check("reset_fpu_n1", bus.fpu_n1, 0);
        check("reset_fpu_n2", bus.fpu_n2, 0);
        check("reset_rsp_result", bus.rsp_result, 0);
        check("reset_dbg_idle", dbg_state, 0);
        set_req(0, 1'b0, 32'd0, 32'd0);
        set_req(1, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            apply_vec(vecs[i]);
        end

        // Reset during ISSUE, then reset release while the multiplier still reports done.
        stub_lat = 8;
        drive_req(0, 32'h40000000, 32'h40400000);
        check("start_in_issue", bus.fpu_start, 1);
        #2 rst_n = 1'b0;
        #1;
        check("start_drops_on_reset", bus.fpu_start, 0);
        check("n1_cleared_on_reset", bus.fpu_n1, 0);
        rsp_log.delete();
        stub_lat  = 0;
        stub_mode = 2;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        set_req(1, 1'b1, 32'h40800000, 32'h3F000000);
        repeat (4) begin
            @(negedge clk);
            check("no_grant_while_done", bus.req1_ready, 0);
        end
        stub_mode = 0;
        wait_ready(1);
        @(posedge clk);
        #1 set_req(1, 1'b0, $urandom, $urandom);
        wait_rsp(1);
        if (rsp_log.size() >= 1) begin
            check("post_reset_owner", rsp_log[0][33], 1);
            check("post_reset_result", rsp_log[0][31:0], 32'h40000000);
        end

        // Random traffic from both requesters.
        fork
            begin
                for (int i = 0; i < 25; i++) begin
                    repeat ($urandom_range(0, 5)) @(posedge clk);
                    drive_req(0, rand_fp(), rand_fp());
                end
            end
            begin
                for (int j = 0; j < 25; j++) begin
                    repeat ($urandom_range(0, 5)) @(posedge clk);
                    drive_req(1, rand_fp(), rand_fp());
                end
            end
        join
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clk);
        end
        check("random_drain", exp_q.size(), 0);

`ifdef FPU_ARB_TIMEOUT_EN
        rsp_log.delete();
        stub_mode = 1;
        drive_req(1, 32'h40400000, 32'h40400000);
        wait_rsp(1);
        if (rsp_log.size() >= 1) begin
            check("timeout_owner", rsp_log[0][33], 1);
            check("timeout_err", rsp_log[0][32], 1);
            check("timeout_result", rsp_log[0][31:0], 32'h7FC00000);
        end
        stub_mode = 0;
        repeat (4) @(posedge clk);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
